eviction_buffer: RTL and testbench
==================================

# eviction_buffer

Write-back buffer between the L2 cache's memory-side port and the cacheline adaptor. Absorbs dirty-line evictions from L2 in one cycle, then drains them to memory while the downstream port is otherwise idle, so L2 refills do not wait behind write-backs. Reads pass through to the adaptor. With forwarding enabled, a read that hits a buffered line is served from the buffer.

## Interface
- DEPTH, 4: number of 256-bit line entries; power of two, at least 2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- up_read_i  in  1  L2 line read request; held until up_resp_o.
- up_write_i  in  1  L2 line write (eviction) request; held until up_resp_o.
- up_address_i  in  32  line address; bits [4:0] ignored.
- up_wdata_i  in  256  eviction data.
- up_resp_o  out  1  one-cycle completion pulse.
- up_rdata_o  out  256  read data, valid while up_resp_o is high.
- dn_read_o  out  1  adaptor read request, registered.
- dn_write_o  out  1  adaptor write request, registered.
- dn_address_o  out  32  adaptor address, with [4:0] forced to 0.
- dn_wdata_o  out  256  adaptor write data.
- dn_resp_i  in  1  adaptor completion pulse.
- dn_rdata_i  in  256  adaptor read data, valid with dn_resp_i.

## Operation
- Storage: circular FIFO of DEPTH entries {tag[31:5], data[255:0]} with head, tail and count. Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRAIN, FETCH, RESP.
- Acceptance guard: no upstream request is accepted in a cycle where up_resp_o is high. The request is still asserted in that cycle and must not be re-accepted.
- Upstream write, in any state:
  - If the tag matches a valid entry other than the head-in-DRAIN, overwrite that entry's data (coalesce). Count is unchanged.
  - Otherwise, if count < DEPTH, push at tail.
  - Otherwise (full), stall with no resp.
  - An accepted write produces up_resp_o in the next cycle.
- Upstream read, only in IDLE:
  - With forwarding, a tag hit returns the matching entry's data on up_resp_o in the next cycle. After coalescing at most one entry can match.
  - On a miss, go to FETCH and drive dn_read_o with up_address_i.
- FETCH: hold dn_read_o and dn_address_o. On dn_resp_i, latch dn_rdata_i, drop dn_read_o and go to RESP.
- RESP: assert up_resp_o and up_rdata_o for one cycle, then go to IDLE.
- DRAIN entry: from IDLE when count > 0 and no upstream read is pending, drive dn_write_o with head tag/data and go to DRAIN.
- DRAIN: hold the request. On dn_resp_i, pop head, drop dn_write_o and return to IDLE.
- Priority in IDLE: upstream read beats drain start. A drain in progress always completes before a read is forwarded.
- Simultaneous write accept and drain pop in the same cycle: count is unchanged and both pointers advance.
- Full and write pending: the write is accepted in the cycle after the draining entry pops.
- dn_read_o and dn_write_o are never high together.

## Timing
- Reset state: FSM in IDLE, head = tail = count = 0, all outputs 0, entry contents don't-care.
- rst asserted mid-transaction aborts it: buffered lines are discarded and dn requests drop in the next cycle.
- Write accept latency: resp in cycle N+1 for a request first seen in cycle N, when not full.
- Read hit latency (forwarding): resp in cycle N+1.
- Read miss latency:
  - dn_read_o rises in N+1.
  - up_resp_o comes one cycle after dn_resp_i.
  - If a drain is in progress, the read waits for it to finish first.
- dn_address_o and dn_wdata_o are stable for the whole time dn_read_o or dn_write_o is high.

## Configuration
- EVICTION_BUFFER_FWD_EN:
  - Defined: read tag hits are served from the buffer, as above.
  - Undefined: a read whose tag matches any entry stays pending in IDLE and lets drains proceed until no entry matches. It is then forwarded as a miss. No buffer data ever reaches up_rdata_o.

## Test plan
- Reset, then idle 5 cycles: all outputs 0. Then write 0x1000_0040 with data A: up_resp_o in the next cycle, then dn_write_o with address 0x1000_0040 and data A; adaptor resp after 3 cycles → dn_write_o drops and count = 0.
- Hold dn_resp_i low and write 5 distinct lines with DEPTH=4: first four resp one cycle apart (with the guard gap); fifth stalls until the first drain resp, then gets resp the following cycle.
- Write 0x2000_0000 with B, then again with C before any drain completes: count = 1 and the later drain writes C.
- With forwarding defined, buffer 0x3000_0020 = D, then read 0x3000_0024: up_rdata_o = D next cycle and dn_read_o never rises. With the macro undefined: drain completes first, then dn_read_o is issued and the adaptor's data is returned.
- Read miss 0x4000_0000 while a drain is outstanding: dn_read_o rises only after the drain resp; up_resp_o comes one cycle after the read dn_resp_i with the adaptor data.
- Assert rst during FETCH: next cycle dn_read_o = 0, count = 0, up_resp_o = 0.

Source files
------------

// File: rtl/eviction_buffer.sv
// -----------------------------------------------------------------------------
// eviction_buffer
//
// Write-back buffer between the L2 memory-side port and the cacheline adaptor.
// Dirty-line evictions from L2 are absorbed into a small circular FIFO in one
// cycle and drained to memory while the downstream port is otherwise idle.
// Line reads pass through to the adaptor. With forwarding enabled, a read that
// hits a buffered line is answered from the buffer.
//
// Optional feature macro: EVICTION_BUFFER_FWD_EN
//   defined   : read tag hits are answered from the buffer.
//   undefined : a hitting read waits in IDLE while drains run until no entry
//               matches, then goes to memory as an ordinary miss.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   up_read_i       L2 line read request, held until up_resp_o
//   up_write_i      L2 eviction request, held until up_resp_o
//   up_address_i    line address, bits [4:0] ignored
//   up_wdata_i      eviction data
//   up_resp_o       one-cycle completion pulse towards L2
//   up_rdata_o      read data, valid while up_resp_o is high
//   dn_read_o       adaptor read request (registered)
//   dn_write_o      adaptor write request (registered)
//   dn_address_o    adaptor address, bits [4:0] always zero
//   dn_wdata_o      adaptor write data
//   dn_resp_i       adaptor completion pulse
//   dn_rdata_i      adaptor read data, valid with dn_resp_i
//   dbg_state_o     current FSM state (debug)
//   dbg_count_o     number of buffered lines (debug)
//
// Handshake: upstream requests are level-held by L2 until the one-cycle
// up_resp_o pulse; a request is never accepted in a cycle where up_resp_o is
// high, so the still-asserted request of the finishing transaction cannot be
// taken twice. Downstream requests are held with stable address/data until the
// adaptor pulses dn_resp_i, and drop in the following cycle.
// -----------------------------------------------------------------------------
module eviction_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_read_i,
  input  logic                     up_write_i,
  input  logic [31:0]              up_address_i,
  input  logic [255:0]             up_wdata_i,
  output logic                     up_resp_o,
  output logic [255:0]             up_rdata_o,
  output logic                     dn_read_o,
  output logic                     dn_write_o,
  output logic [31:0]              dn_address_o,
  output logic [255:0]             dn_wdata_o,
  input  logic                     dn_resp_i,
  input  logic [255:0]             dn_rdata_i,
  output logic [1:0]               dbg_state_o,
  output logic [$clog2(DEPTH):0]   dbg_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [26:0]   tag_q  [DEPTH];
  logic [26:0]   tag_d  [DEPTH];
  logic [255:0]  data_q [DEPTH];
  logic [255:0]  data_d [DEPTH];

  logic          up_resp_q, up_resp_d;
  logic [255:0]  up_rdata_q, up_rdata_d;
  logic          dn_read_q, dn_read_d;
  logic          dn_write_q, dn_write_d;
  logic [31:0]   dn_addr_q, dn_addr_d;
  logic [255:0]  dn_wdata_q, dn_wdata_d;

  // ---------------------------------------------------------------------------
  // Tag lookup against the occupied FIFO slots
  // ---------------------------------------------------------------------------
  logic [26:0]      up_tag;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] tag_hit;
  logic             any_hit;

  assign up_tag = up_address_i[31:5];

  // Offset bits of the line address carry no information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^up_address_i[4:0];

  always_comb begin
    entry_valid = '0;
    tag_hit     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // A slot is occupied when its distance from head is below count.
      entry_valid[i] = {1'b0, PW'(PW'(i) - head_q)} < count_q;
      tag_hit[i]     = entry_valid[i] && (tag_q[i] == up_tag);
    end
    any_hit = |tag_hit;
  end

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  logic read_pending;
  logic read_go;
  logic read_fwd;
  logic drain_start;
  logic head_busy;
  logic write_req;
  logic write_coalesce;
  logic write_push;
  logic pop;

  assign read_pending = up_read_i && !up_resp_q;

`ifdef EVICTION_BUFFER_FWD_EN
  logic [255:0] hit_data;

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_hit[i]) hit_data = data_q[i];
    end
  end

  assign read_go  = read_pending && (state_q == S_IDLE);
  assign read_fwd = read_go && any_hit;
`else
  // A hitting read is held back so older buffered data reaches memory first.
  assign read_go  = read_pending && (state_q == S_IDLE) && !any_hit;
  assign read_fwd = 1'b0;
`endif

  assign drain_start = (state_q == S_IDLE) && (count_q != '0) && !read_go;
  assign pop         = (state_q == S_DRAIN) && dn_resp_i;

  // The head slot is frozen once its data has been (or is being) copied onto
  // the downstream write; a write to that tag must create a fresh entry.
  assign head_busy = (state_q == S_DRAIN) || drain_start;

  logic [DEPTH-1:0] coal_mask;
  logic             coal_any;
  logic [PW-1:0]    coal_idx;

  always_comb begin
    coal_mask = tag_hit;
    if (head_busy) coal_mask[head_q] = 1'b0;
    coal_any = |coal_mask;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (coal_mask[i]) coal_idx = PW'(i);
    end
  end

  assign write_req      = up_write_i && !up_resp_q;
  assign write_coalesce = write_req && coal_any;
  assign write_push     = write_req && !coal_any && (count_q != FULL_COUNT);

  // ---------------------------------------------------------------------------
  // FSM and pointer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    up_resp_d  = 1'b0;
    up_rdata_d = up_rdata_q;
    dn_read_d  = dn_read_q;
    dn_write_d = dn_write_q;
    dn_addr_d  = dn_addr_q;
    dn_wdata_d = dn_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (read_fwd) begin
`ifdef EVICTION_BUFFER_FWD_EN
          up_resp_d  = 1'b1;
          up_rdata_d = hit_data;
`endif
        end else if (read_go) begin
          state_d   = S_FETCH;
          dn_read_d = 1'b1;
          dn_addr_d = {up_tag, 5'b0};
        end else if (drain_start) begin
          state_d    = S_DRAIN;
          dn_write_d = 1'b1;
          dn_addr_d  = {tag_q[head_q], 5'b0};
          dn_wdata_d = data_q[head_q];
        end
      end
      S_DRAIN: begin
        if (dn_resp_i) begin
          state_d    = S_IDLE;
          dn_write_d = 1'b0;
          head_d     = head_q + PW'(1);
        end
      end
      S_FETCH: begin
        if (dn_resp_i) begin
          state_d    = S_RESP;
          dn_read_d  = 1'b0;
          up_rdata_d = dn_rdata_i;
          up_resp_d  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (write_coalesce || write_push) up_resp_d = 1'b1;
    if (write_push) tail_d = tail_q + PW'(1);

    // Push and pop in the same cycle leave the occupancy unchanged.
    case ({write_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry storage (contents need no reset: occupancy is tracked by count)
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    if (write_coalesce) data_d[coal_idx] = up_wdata_i;
    if (write_push) begin
      tag_d[tail_q]  = up_tag;
      data_d[tail_q] = up_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      up_resp_q  <= 1'b0;
      up_rdata_q <= '0;
      dn_read_q  <= 1'b0;
      dn_write_q <= 1'b0;
      dn_addr_q  <= '0;
      dn_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      up_resp_q  <= up_resp_d;
      up_rdata_q <= up_rdata_d;
      dn_read_q  <= dn_read_d;
      dn_write_q <= dn_write_d;
      dn_addr_q  <= dn_addr_d;
      dn_wdata_q <= dn_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign up_resp_o    = up_resp_q;
  assign up_rdata_o   = up_rdata_q;
  assign dn_read_o    = dn_read_q;
  assign dn_write_o   = dn_write_q;
  assign dn_address_o = dn_addr_q;
  assign dn_wdata_o   = dn_wdata_q;
  assign dbg_state_o  = state_q;
  assign dbg_count_o  = count_q;

endmodule

// File: tb/tb_eviction_buffer.sv
// -----------------------------------------------------------------------------
// tb_eviction_buffer
//
// Directed scenarios for the eviction buffer followed by a randomized phase.
// The adaptor is modelled as a line-granular memory with a programmable
// response latency; the reference is the L2's view of memory (last value
// written per line), so every read must return that value and, once the
// buffer is empty, the adaptor memory must equal it.
// -----------------------------------------------------------------------------
module tb_eviction_buffer;

  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         up_read_i;
  logic         up_write_i;
  logic [31:0]  up_address_i;
  logic [255:0] up_wdata_i;
  logic         up_resp_o;
  logic [255:0] up_rdata_o;
  logic         dn_read_o;
  logic         dn_write_o;
  logic [31:0]  dn_address_o;
  logic [255:0] dn_wdata_o;
  logic         dn_resp_i;
  logic [255:0] dn_rdata_i;
  logic [1:0]   dbg_state_o;
  logic [2:0]   dbg_count_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  eviction_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .up_read_i    (up_read_i),
    .up_write_i   (up_write_i),
    .up_address_i (up_address_i),
    .up_wdata_i   (up_wdata_i),
    .up_resp_o    (up_resp_o),
    .up_rdata_o   (up_rdata_o),
    .dn_read_o    (dn_read_o),
    .dn_write_o   (dn_write_o),
    .dn_address_o (dn_address_o),
    .dn_wdata_o   (dn_wdata_o),
    .dn_resp_i    (dn_resp_i),
    .dn_rdata_i   (dn_rdata_i),
    .dbg_state_o  (dbg_state_o),
    .dbg_count_o  (dbg_count_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  logic [287:0] exp_q[$];     // expected drain writes {address, data}
  logic [287:0] drain_q[$];   // drain writes seen by the adaptor
  logic [255:0] mem [logic [26:0]];
  logic [255:0] ref_mem [logic [26:0]];

  logic hold_dn = 1'b0;
  int   dn_lat  = 1;
  int   dn_wait = 0;

  int cyc = 0;
  int last_wr_resp_cyc = -1;
  int last_rd_resp_cyc = -1;
  int last_rd_rise_cyc = -1;
  int last_up_resp_cyc = -1;
  int rd_rises = 0;

  function automatic logic [255:0] mem_init(input logic [26:0] t);
    mem_init = {8{5'b10101, t}};
  endfunction

  task automatic check(input string name, input logic [287:0] obs, input logic [287:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Adaptor model: responds dn_lat cycles after a request is seen
  // ---------------------------------------------------------------------------
  initial begin
    dn_resp_i  = 1'b0;
    dn_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      dn_resp_i = 1'b0;
      if (rst) begin
        dn_wait = 0;
      end else if ((dn_read_o || dn_write_o) && !hold_dn) begin
        if (dn_wait >= dn_lat) begin
          dn_resp_i = 1'b1;
          dn_wait   = 0;
          if (dn_write_o) begin
            mem[dn_address_o[31:5]] = dn_wdata_o;
            drain_q.push_back({dn_address_o, dn_wdata_o});
          end else begin
            dn_rdata_i = mem.exists(dn_address_o[31:5]) ? mem[dn_address_o[31:5]]
                                                        : mem_init(dn_address_o[31:5]);
          end
        end else begin
          dn_wait++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol monitor: exclusivity and stability of downstream requests
  // ---------------------------------------------------------------------------
  initial begin
    logic         prev_rd;
    logic         prev_wr;
    logic [31:0]  prev_addr;
    logic [255:0] prev_wdata;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (dn_read_o || dn_write_o)
        check("dn_excl", 288'(dn_read_o && dn_write_o), 288'(0));
      if (prev_rd && dn_read_o)
        check("dn_rd_addr_stable", 288'(dn_address_o), 288'(prev_addr));
      if (prev_wr && dn_write_o)
        check("dn_wr_stable", {dn_address_o, dn_wdata_o}, {prev_addr, prev_wdata});
      if (dn_resp_i && dn_write_o) last_wr_resp_cyc = cyc;
      if (dn_resp_i && dn_read_o)  last_rd_resp_cyc = cyc;
      if (dn_read_o && !prev_rd) begin
        last_rd_rise_cyc = cyc;
        rd_rises++;
      end
      if (up_resp_o) last_up_resp_cyc = cyc;
      prev_rd    = dn_read_o;
      prev_wr    = dn_write_o;
      prev_addr  = dn_address_o;
      prev_wdata = dn_wdata_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // lat = cycles from the request's first cycle to up_resp_o, -1 on timeout
  task automatic up_req(input logic is_wr, input logic [31:0] a, input logic [255:0] d,
                        input int max_cyc, output int lat, output logic [255:0] rd);
    up_read_i    = !is_wr;
    up_write_i   = is_wr;
    up_address_i = a;
    up_wdata_i   = d;
    lat = -1;
    rd  = 'x;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (up_resp_o) begin
        lat = c;
        rd  = up_rdata_o;
        break;
      end
    end
    @(posedge clk); #1;
    up_read_i  = 1'b0;
    up_write_i = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int c;
    c = 0;
    while (c < 400 && !(dbg_count_o == 3'd0 && !dn_read_o && !dn_write_o && !up_resp_o)) begin
      @(negedge clk);
      c++;
    end
    check(name, 288'(c < 400), 288'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_drains(input string name);
    logic [287:0] e;
    logic [287:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (drain_q.size() > 0) ? drain_q.pop_front() : 'x;
      check(name, o, e);
    end
    check({name, "_extra"}, 288'(drain_q.size()), 288'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           lat;
    int           c_resp;
    int           c_up;
    int           rises_before;
    logic [255:0] rd;
    logic [255:0] d_a, d_b, d_c, d_d, d_x;
    logic [26:0]  t;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] exp_rd;

    rst          = 1'b1;
    up_read_i    = 1'b0;
    up_write_i   = 1'b0;
    up_address_i = '0;
    up_wdata_i   = '0;
    d_a = {8{32'hAAAA_0001}};
    d_b = {8{32'hBBBB_0002}};
    d_c = {8{32'hCCCC_0003}};
    d_d = {8{32'hDDDD_0004}};
    d_x = {8{32'h1234_5678}};

    // ---- reset and idle -------------------------------------------------
    tick(3);
    rst = 1'b0;
    tick(5);
    @(negedge clk);
    check("rst_up_resp",  288'(up_resp_o),    288'(0));
    check("rst_up_rdata", 288'(up_rdata_o),   288'(0));
    check("rst_dn_read",  288'(dn_read_o),    288'(0));
    check("rst_dn_write", 288'(dn_write_o),   288'(0));
    check("rst_dn_addr",  288'(dn_address_o), 288'(0));
    check("rst_dn_wdata", 288'(dn_wdata_o),   288'(0));
    check("rst_count",    288'(dbg_count_o),  288'(0));
    @(posedge clk); #1;

    // ---- single eviction and drain --------------------------------------
    dn_lat = 3;
    up_req(1'b1, 32'h1000_0040, d_a, 20, lat, rd);
    check("wr_a_lat", 288'(lat), 288'(1));
    exp_q.push_back({32'h1000_0040, d_a});
    wait_quiet("drain_a_done");
    check("drain_a_count", 288'(dbg_count_o), 288'(0));
    check_drains("drain_a");

    // ---- coalescing behind a held drain ----------------------------------
    hold_dn = 1'b1;
    dn_lat  = 1;
    up_req(1'b1, 32'h5000_0000, d_x, 20, lat, rd);
    check("coal_x_lat", 288'(lat), 288'(1));
    up_req(1'b1, 32'h2000_0000, d_b, 20, lat, rd);
    check("coal_b_lat", 288'(lat), 288'(1));
    up_req(1'b1, 32'h2000_0000, d_c, 20, lat, rd);
    check("coal_c_lat", 288'(lat), 288'(1));
    check("coal_count", 288'(dbg_count_o), 288'(2));
    hold_dn = 1'b0;
    exp_q.push_back({32'h5000_0000, d_x});
    exp_q.push_back({32'h2000_0000, d_c});
    wait_quiet("coal_done");
    check_drains("coal_drain");

    // ---- fill to DEPTH, fifth write stalls until a drain pops ------------
    hold_dn = 1'b1;
    dn_lat  = 1;
    for (int i = 0; i < 4; i++) begin
      up_req(1'b1, 32'h7000_0000 + 32'(i * 32), {8{32'(i + 16)}}, 20, lat, rd);
      check("fill_lat", 288'(lat), 288'(1));
      exp_q.push_back({32'h7000_0000 + 32'(i * 32), {8{32'(i + 16)}}});
    end
    check("fill_count", 288'(dbg_count_o), 288'(4));
    up_write_i   = 1'b1;
    up_address_i = 32'h7000_0080;
    up_wdata_i   = {8{32'd20}};
    c_resp = -1;
    c_up   = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 4) hold_dn = 1'b0;
      if (dn_resp_i && c_resp < 0) c_resp = c;
      if (up_resp_o) begin
        c_up = c;
        break;
      end
    end
    @(posedge clk); #1;
    up_write_i = 1'b0;
    exp_q.push_back({32'h7000_0080, {8{32'd20}}});
    check("full_stall_seen", 288'(c_resp >= 5), 288'(1));
    check("full_accept_time", 288'(c_up), 288'(c_resp + 2));
    wait_quiet("full_done");
    check_drains("full_drain");

    // ---- read of a buffered line ----------------------------------------
    dn_lat = 6;
    up_req(1'b1, 32'h3100_0000, d_x, 20, lat, rd);
    up_req(1'b1, 32'h3000_0020, d_d, 20, lat, rd);
    check("fwd_wr_lat", 288'(lat), 288'(1));
    rises_before = rd_rises;
    up_req(1'b0, 32'h3000_0024, '0, 100, lat, rd);
    check("fwd_rdata", 288'(rd), 288'(d_d));
`ifdef EVICTION_BUFFER_FWD_EN
    check("fwd_no_dn_read", 288'(rd_rises), 288'(rises_before));
`else
    check("nofwd_dn_read", 288'(rd_rises), 288'(rises_before + 1));
    check("nofwd_drain_first", 288'(last_rd_rise_cyc > last_wr_resp_cyc), 288'(1));
`endif
    exp_q.push_back({32'h3100_0000, d_x});
    exp_q.push_back({32'h3000_0020, d_d});
    wait_quiet("fwd_done");
    check_drains("fwd_drain");

    // ---- read miss behind an outstanding drain ---------------------------
    dn_lat = 5;
    up_req(1'b1, 32'h4100_0000, d_b, 20, lat, rd);
    up_req(1'b0, 32'h4000_0000, '0, 100, lat, rd);
    check("miss_rdata", 288'(rd), 288'(mem_init(27'h200_0000)));
    check("miss_rd_rise", 288'(last_rd_rise_cyc), 288'(last_wr_resp_cyc + 2));
    check("miss_up_resp", 288'(last_up_resp_cyc), 288'(last_rd_resp_cyc + 1));
    exp_q.push_back({32'h4100_0000, d_b});
    wait_quiet("miss_done");
    check_drains("miss_drain");

    // ---- reset during FETCH ---------------------------------------------
    dn_lat = 2;
    up_req(1'b1, 32'h6100_0000, d_a, 20, lat, rd);
    up_req(1'b1, 32'h6200_0000, d_b, 20, lat, rd);
    up_read_i    = 1'b1;
    up_address_i = 32'h6000_0000;
    c_up = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dn_read_o) begin
        c_up = c;
        break;
      end
    end
    hold_dn = 1'b1;
    check("fetch_reached", 288'(c_up >= 0), 288'(1));
    check("fetch_count", 288'(dbg_count_o), 288'(1));
    @(posedge clk); #1;
    rst       = 1'b1;
    up_read_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_dn_read",  288'(dn_read_o),   288'(0));
    check("abort_dn_write", 288'(dn_write_o),  288'(0));
    check("abort_up_resp",  288'(up_resp_o),   288'(0));
    check("abort_count",    288'(dbg_count_o), 288'(0));
    @(posedge clk); #1;
    rst     = 1'b0;
    hold_dn = 1'b0;
    mem.delete();
    ref_mem.delete();
    drain_q.delete();
    exp_q.delete();
    tick(2);

    // ---- randomized traffic against the memory-view reference -----------
    for (int n = 0; n < 160; n++) begin
      t      = 27'h400_0000 + 27'($urandom_range(0, 5));
      a      = {t, 5'($urandom_range(0, 31))};
      dn_lat = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        up_req(1'b1, a, d, 300, lat, rd);
        check("rnd_wr_resp", 288'(lat >= 1), 288'(1));
        ref_mem[t] = d;
      end else begin
        exp_rd = ref_mem.exists(t) ? ref_mem[t] : mem_init(t);
        up_req(1'b0, a, '0, 300, lat, rd);
        check("rnd_rd_resp", 288'(lat >= 1), 288'(1));
        check("rnd_rd_data", 288'(rd), 288'(exp_rd));
      end
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 6));
    end
    wait_quiet("rnd_done");
    foreach (ref_mem[k]) begin
      check("rnd_mem", 288'(mem.exists(k) ? mem[k] : 'x), 288'(ref_mem[k]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
